// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Ceiling log2 with a floor of 1 so a one-clock bit period still gets a real counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses o_sample at mid-bit, or on every clock when a bit is one clock long.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_sample
);
  import uart_pkg::*;

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  // Preload so the first wrap lands CLKS_PER_BIT/2 clocks after the start edge.
  localparam logic [CNT_W-1:0] INIT = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= INIT;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sample = (CLKS_PER_BIT == 1) || w_at_last;

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: bit-timer driven FSM, LSB-first shift register, ready/framing-error strobes.
module uart_rx_unit #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 frame_err
);
  import uart_pkg::*;

  localparam int             IDX_W    = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  rx_state_e              r_state, w_state_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt, w_shifted;
  logic [IDX_W-1:0]       r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0]   r_data, w_data_nxt;
  logic                   r_rdy, w_rdy_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_sample;

  // Timer free-runs only inside a frame; IDLE holds it at its mid-bit preload.
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == IDLE),
    .o_sample (w_sample)
  );

  assign w_shifted = {rx_in, r_shift[DATA_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_data    <= w_data_nxt;
      r_rdy     <= w_rdy_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_data_nxt    = r_data;
    w_rdy_nxt     = 1'b0;
    w_err_nxt     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (CLKS_PER_BIT == 1) begin
          // A single-clock bit means the low sample already is the start bit.
          if (w_sample && !rx_in) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = '0;
          end
        end else if (!rx_in) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_sample) begin
          if (!rx_in) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_sample) begin
          w_shift_nxt = w_shifted;
          if (r_bit_idx == LAST_BIT) begin
            w_data_nxt  = w_shifted;
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_sample) begin
          w_rdy_nxt   = rx_in;
          w_err_nxt   = !rx_in;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_data   = r_data;
  assign rx_rdy    = r_rdy;
  assign frame_err = r_err;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench: per-cycle vector table on a 1-clock-per-bit receiver, hand sequences on a 16x one.
module tb_uart_rx_unit;

  typedef struct {
    logic       rst;
    logic       rx;
    logic       rdy;
    logic       err;
    logic [7:0] data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1, rx16;
  logic [7:0] data1, data16;
  logic       rdy1, err1, rdy16, err16;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  logic [7:0] model_data;

  always #5 clk = ~clk;

  uart_rx_unit #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx1),
    .rx_data   (data1),
    .rx_rdy    (rdy1),
    .frame_err (err1)
  );

  uart_rx_unit #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx16),
    .rx_data   (data16),
    .rx_rdy    (rdy16),
    .frame_err (err16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic rx, input logic rdy, input logic err);
    vec_t v;
    v.rst  = r;
    v.rx   = rx;
    v.rdy  = rdy;
    v.err  = err;
    v.data = model_data;
    vecs.push_back(v);
  endtask

  // One 10-bit frame, one vector per bit; the byte becomes visible after the 8th data bit.
  task automatic add_frame(input logic [7:0] b, input logic stop);
    logic rx;
    for (int i = 0; i < 10; i++) begin
      rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      if (i == 8) model_data = b;
      add_vec(1'b0, rx, (i == 9) && stop, (i == 9) && !stop);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add_vec(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Drives one frame at 16 clocks/bit plus an idle tail; reports strobe counts and first strobe cycle.
  task automatic send16(input logic [7:0] b, input logic stop,
                        output int rdy_n, output int err_n, output int first);
    logic [9:0] f;
    int cyc;
    f = {stop, b, 1'b0};
    rdy_n = 0;
    err_n = 0;
    first = -1;
    cyc   = 0;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < 16; c++) begin
        rx16 = (i < 10) ? f[i] : 1'b1;
        @(posedge clk);
        #1;
        if (rdy16) rdy_n++;
        if (err16) err_n++;
        if ((rdy16 || err16) && first < 0) first = cyc;
        cyc++;
      end
    end
  endtask

  initial begin
    int r_n, e_n, first;

    rst  = 1'b1;
    rx1  = 1'b1;
    rx16 = 1'b1;

    model_data = 8'h00;
    for (int i = 0; i < 5; i++) add_vec(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    add_frame(8'hD3, 1'b1);
    idle(2);
    add_frame(8'hD3, 1'b0);
    idle(1);
    add_frame(8'h55, 1'b1);
    add_frame(8'hA3, 1'b1);
    idle(2);
    // Reset after the start bit and 4 data bits: partial frame discarded, rx_data cleared.
    add_vec(1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0);
    model_data = 8'h00;
    add_vec(1'b1, 1'b1, 1'b0, 1'b0);
    add_frame(8'h81, 1'b1);
    idle(2);
    // Line stuck low: two 10-bit windows, each ending in a framing error.
    add_frame(8'h00, 1'b0);
    add_frame(8'h00, 1'b0);
    idle(3);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      rx1 = vecs[i].rx;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rx_rdy", i), 32'(rdy1), 32'(vecs[i].rdy));
      check($sformatf("vec%0d frame_err", i), 32'(err1), 32'(vecs[i].err));
      check($sformatf("vec%0d rx_data", i), 32'(data1), 32'(vecs[i].data));
      check($sformatf("vec%0d x16 idle strobes", i), 32'({rdy16, err16}), 32'd0);
      check($sformatf("vec%0d x16 rx_data", i), 32'(data16), 32'h00);
    end

    // Start edge is cycle 0; stop sample at 16/2 + 9*16 = 152.
    send16(8'h3C, 1'b1, r_n, e_n, first);
    check("x16 0x3C rdy count", 32'(r_n), 32'd1);
    check("x16 0x3C err count", 32'(e_n), 32'd0);
    check("x16 0x3C strobe cycle", 32'(first), 32'd152);
    check("x16 0x3C rx_data", 32'(data16), 32'h3C);

    send16(8'hC3, 1'b0, r_n, e_n, first);
    check("x16 ferr rdy count", 32'(r_n), 32'd0);
    check("x16 ferr err count", 32'(e_n), 32'd1);
    check("x16 ferr strobe cycle", 32'(first), 32'd152);
    check("x16 ferr rx_data", 32'(data16), 32'hC3);

    // 3-clock glitch: mid-bit sample sees high, no strobe, byte unchanged.
    r_n = 0;
    e_n = 0;
    for (int c = 0; c < 43; c++) begin
      rx16 = (c < 3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (rdy16) r_n++;
      if (err16) e_n++;
    end
    check("x16 glitch rdy count", 32'(r_n), 32'd0);
    check("x16 glitch err count", 32'(e_n), 32'd0);
    check("x16 glitch rx_data", 32'(data16), 32'hC3);

    // A clean frame right after the glitch confirms the receiver went back to IDLE.
    send16(8'hA5, 1'b1, r_n, e_n, first);
    check("x16 post-glitch rdy count", 32'(r_n), 32'd1);
    check("x16 post-glitch err count", 32'(e_n), 32'd0);
    check("x16 post-glitch strobe cycle", 32'(first), 32'd152);
    check("x16 post-glitch rx_data", 32'(data16), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- 8N1 UART receiver: start bit (0), 8 data bits LSB first, one stop bit (1).
- Converts the serial line `rx_in` into a parallel byte with a one-cycle ready strobe.
- Sits behind the board-level input synchroniser; `rx_in` arrives already synchronous to `clk`.
- Bit period is set in clocks by parameter; the default of 1 gives one bit per clock for fast simulation.

Parameters:
- CLKS_PER_BIT, default 1: clocks per serial bit, legal range 1..65535.
- DATA_BITS, default 8: data bits per frame; only 8 is supported, kept for package consistency.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  serial line; idles high.
- rx_data  output  8  last received byte, registered.
- rx_rdy  output  1  one-cycle strobe: a frame with a valid stop bit has completed.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; rx_data=8'h00; rx_rdy=0; frame_err=0; counters cleared.
  - Reset overrides any frame in progress; the partial frame is discarded with no strobe.
- States: IDLE, START, DATA, STOP.
- Bit timer: counts 0..CLKS_PER_BIT-1. A "bit sample" is the edge where the timer reaches its sample point.
  - CLKS_PER_BIT=1: every edge is a sample edge.
  - CLKS_PER_BIT>1: the sample point is mid-bit; the first sample is taken CLKS_PER_BIT/2 (integer division) clocks after the start edge is detected, then every CLKS_PER_BIT clocks.
- IDLE:
  - CLKS_PER_BIT=1: a sample of rx_in=0 is the start bit itself; go to DATA, bit index 0.
  - CLKS_PER_BIT>1: rx_in=0 moves to START.
- START (CLKS_PER_BIT>1 only): at the mid-bit sample:
  - rx_in=0: go to DATA.
  - rx_in=1: glitch; return to IDLE with no strobe.
- DATA:
  - On each sample, shift rx_in in at the MSB end, so after 8 samples the first-received bit is in bit 0.
  - On the 8th sample, the complete byte is written to rx_data on that same edge, then go to STOP.
  - rx_data therefore holds the new byte before the stop bit is sampled.
  - rx_data keeps its value until the next frame's 8th data sample.
- STOP, on its sample:
  - rx_in=1: rx_rdy=1 for exactly one cycle.
  - rx_in=0: frame_err=1 for exactly one cycle; rx_data still keeps the new byte.
  - Either way, return to IDLE on the same edge.
- Back-to-back frames: a start bit sampled on the edge immediately after STOP is accepted; no idle gap is required.
- rx_rdy and frame_err are never asserted together.
- Line held low indefinitely: each 10-bit window is treated as a frame; frame_err pulses once per window.
- Latency at CLKS_PER_BIT=1: the start bit is sampled at edge S, data bits at S+1..S+8, rx_data valid after S+8, stop bit sampled and rx_rdy asserted at S+9.
- X on rx_in before reset is don't-care; outputs are defined only after the first reset edge.

Decomposition:
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP};
  - constant DATA_BITS=8;
  - bit-counter width function clog2(CLKS_PER_BIT).
- One natural sub-module: `uart_bit_timer`, which counts clocks and emits a sample pulse at the mid-bit or, when CLKS_PER_BIT=1, every cycle.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset: hold rst=1 for 5 cycles with rx_in=1 -> rx_data=8'h00, rx_rdy=0, frame_err=0; no activity after release while the line idles.
- Nominal, CLKS_PER_BIT=1: one clock per bit, drive 0, 1,1,0,0,1,0,1,1, 1 -> rx_data=8'b11010011 (0xD3) on the edge after the stop bit is driven; rx_rdy single pulse; frame_err=0.
- Framing error: same frame with stop bit 0 -> frame_err one pulse; rx_rdy=0; rx_data=8'hD3.
- Back-to-back, CLKS_PER_BIT=1: 0x55 immediately followed by 0xA3 -> two rx_rdy pulses exactly 10 cycles apart; rx_data 0x55 then 0xA3.
- Oversampled, CLKS_PER_BIT=16:
  - 0x3C with bits held 16 clocks each -> rx_data=0x3C, rx_rdy pulse.
  - A 3-clock low glitch on an idle line -> no strobe; state returns to IDLE.
- Reset mid-frame: assert rst after 4 data bits, then send 0x81 -> only one rx_rdy, with rx_data=0x81.
